// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the DATA_RAM access controller.
package data_mem_arbiter_pkg;

  // Controller phases: wait for a request, present it to the RAM, collect read data.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    READ   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/data_mem_arbiter_rr.sv
// Combinational round-robin selector: first set request strictly after the
// pointer, wrapping modulo N. Produces both a one-hot grant and its index.
module round_robin_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic [IW-1:0] cand;
  logic          found;

  // Scan the N positions after the pointer; the first requester found wins.
  always_comb begin
    // NOTE: every output and temporary gets a default first so no path leaves a latch.
    grant = '0;
    index = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(pointer) + i) % N);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        index       = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin access controller in front of the shared DATA_RAM. One
// transaction at a time: writes take 2 cycles, reads 3 cycles.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int CORE_COUNT = 4,
  parameter int WIDTH      = 12,
  parameter int DEPTH      = 4096,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [CORE_COUNT-1:0]                 core_req,
  input  logic [CORE_COUNT-1:0]                 core_wrEn,
  input  logic [CORE_COUNT-1:0][ADDR_WIDTH-1:0] core_addr,
  input  logic [CORE_COUNT-1:0][WIDTH-1:0]      core_dataIn,
  output logic [CORE_COUNT-1:0]                 core_gnt,
  output logic [CORE_COUNT-1:0]                 core_ack,
  output logic [WIDTH-1:0]                      core_dataOut,
  output logic                                  ram_wrEn,
  output logic [ADDR_WIDTH-1:0]                 ram_addr,
  output logic [WIDTH-1:0]                      ram_dataIn,
  input  logic [WIDTH-1:0]                      ram_dataOut,
  output logic                                  busy
);

  localparam int IDX_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
  localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(CORE_COUNT - 1);

  arb_state_t                state_q, state_d;
  logic [CORE_COUNT-1:0]     gnt_q, gnt_d;
  logic [CORE_COUNT-1:0]     ack_q, ack_d;
  logic [WIDTH-1:0]          dout_q, dout_d;
  logic                      we_q, we_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [WIDTH-1:0]          din_q, din_d;
  logic [IDX_W-1:0]          owner_q, owner_d;
  logic                      is_read_q, is_read_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;

  logic [CORE_COUNT-1:0]     rr_grant;
  logic [IDX_W-1:0]          rr_index;

  round_robin_arbiter #(
    .N  (CORE_COUNT),
    .IW (IDX_W)
  ) u_rr (
    .req     (core_req),
    .pointer (ptr_q),
    .grant   (rr_grant),
    .index   (rr_index)
  );

  // Next-state and next-output decode; gnt, ack and wrEn default low so they pulse.
  always_comb begin
    state_d   = state_q;
    gnt_d     = '0;
    ack_d     = '0;
    dout_d    = dout_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    din_d     = din_q;
    owner_d   = owner_q;
    is_read_d = is_read_q;
    ptr_d     = ptr_q;
    case (state_q)
      IDLE: begin
        if (|core_req) begin
          addr_d    = core_addr[rr_index];
          din_d     = core_dataIn[rr_index];
          we_d      = core_wrEn[rr_index];
          gnt_d     = rr_grant;
          owner_d   = rr_index;
          is_read_d = ~core_wrEn[rr_index];
          ptr_d     = rr_index;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        // The RAM samples address/wrEn at the end of this cycle; a write is done here.
        if (is_read_q) begin
          state_d = READ;
        end else begin
          ack_d[owner_q] = 1'b1;
          state_d        = IDLE;
        end
      end
      READ: begin
        dout_d         = ram_dataOut;
        ack_d[owner_q] = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ack_q     <= '0;
      dout_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      owner_q   <= '0;
      is_read_q <= 1'b0;
      ptr_q     <= PTR_RESET;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      dout_q    <= dout_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      owner_q   <= owner_d;
      is_read_q <= is_read_d;
      ptr_q     <= ptr_d;
    end
  end

  assign core_gnt     = gnt_q;
  assign core_ack     = ack_q;
  assign core_dataOut = dout_q;
  assign ram_addr     = addr_q;
  assign ram_dataIn   = din_q;
  // The RAM samples wrEn on the same edge that applies reset, so the registered
  // strobe is masked by the (clock-synchronous) reset to abort an in-flight write.
  assign ram_wrEn     = we_q & ~rst;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter with a behavioural DATA_RAM model.
module tb_data_mem_arbiter;

  localparam int CC = 4;
  localparam int W  = 12;
  localparam int AW = 12;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [CC-1:0]        core_req;
  logic [CC-1:0]        core_wrEn;
  logic [CC-1:0][AW-1:0] core_addr;
  logic [CC-1:0][W-1:0] core_dataIn;
  logic [CC-1:0]        core_gnt;
  logic [CC-1:0]        core_ack;
  logic [W-1:0]         core_dataOut;
  logic                 ram_wrEn;
  logic [AW-1:0]        ram_addr;
  logic [W-1:0]         ram_dataIn;
  logic [W-1:0]         ram_dataOut;
  logic                 busy;

  data_mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .core_req     (core_req),
    .core_wrEn    (core_wrEn),
    .core_addr    (core_addr),
    .core_dataIn  (core_dataIn),
    .core_gnt     (core_gnt),
    .core_ack     (core_ack),
    .core_dataOut (core_dataOut),
    .ram_wrEn     (ram_wrEn),
    .ram_addr     (ram_addr),
    .ram_dataIn   (ram_dataIn),
    .ram_dataOut  (ram_dataOut),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // DATA_RAM: synchronous write, registered-address read.
  logic [W-1:0]  mem [0:4095];
  logic [AW-1:0] ram_addr_reg;
  always @(posedge clk) begin
    if (ram_wrEn) mem[ram_addr] <= ram_dataIn;
    ram_addr_reg <= ram_addr;
  end
  assign ram_dataOut = mem[ram_addr_reg];

  typedef struct {
    int          core;
    bit          wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } txn_t;

  txn_t exp_q[$];
  txn_t ops [CC][16];
  int   n_ops [CC];
  int   next_op [CC];
  bit   outst [CC];
  int   req_cyc [CC];
  int   gnt_cyc_core [CC];
  int   cyc, gnt_cyc, gnt_cnt, last_ack_cyc;
  bit   prev_busy, busy_at_ack, busy_before_ack;
  int   n_tests, n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic add_op(input int core, input bit wr, input logic [AW-1:0] addr,
                        input logic [W-1:0] data);
    txn_t t;
    t.core = core;
    t.wr   = wr;
    t.addr = addr;
    t.data = data;
    ops[core][n_ops[core]] = t;
    n_ops[core]++;
    exp_q.push_back(t);
  endtask

  task automatic flush();
    core_req = '0;
    exp_q.delete();
    for (int i = 0; i < CC; i++) begin
      outst[i]   = 1'b0;
      n_ops[i]   = 0;
      next_op[i] = 0;
    end
  endtask

  // Compare DUT outputs against the front of the expected-transaction queue.
  task automatic monitor();
    txn_t e;
    logic [CC-1:0] oh;
    if (|core_gnt) begin
      gnt_cnt++;
      gnt_cyc = cyc;
      for (int i = 0; i < CC; i++) if (core_gnt[i]) gnt_cyc_core[i] = cyc;
      if (exp_q.size() == 0) begin
        check("gnt_unexpected", 32'(core_gnt), 0);
      end else begin
        e  = exp_q[0];
        oh = CC'(1) << e.core;
        check("gnt_core", 32'(core_gnt), 32'(oh));
        check("gnt_wren", 32'(ram_wrEn), 32'(e.wr));
        check("gnt_addr", 32'(ram_addr), 32'(e.addr));
        if (e.wr) check("gnt_wdata", 32'(ram_dataIn), 32'(e.data));
      end
    end else if (ram_wrEn) begin
      check("wren_without_gnt", 32'(ram_wrEn), 0);
    end
    if (|core_ack) begin
      busy_at_ack     = busy;
      busy_before_ack = prev_busy;
      last_ack_cyc    = cyc;
      if (exp_q.size() == 0) begin
        check("ack_unexpected", 32'(core_ack), 0);
      end else begin
        e  = exp_q.pop_front();
        oh = CC'(1) << e.core;
        check("ack_core", 32'(core_ack), 32'(oh));
        check("ack_latency", cyc - gnt_cyc, e.wr ? 1 : 2);
        if (!e.wr) check("read_data", 32'(core_dataOut), 32'(e.data));
      end
    end
    prev_busy = busy;
  endtask

  // Core-side protocol: hold until gnt, drop, re-request from the ack cycle on.
  task automatic drive();
    for (int i = 0; i < CC; i++) begin
      if (core_gnt[i] && core_req[i]) begin
        core_req[i] = 1'b0;
        outst[i]    = 1'b1;
        next_op[i]++;
      end
      if (core_ack[i]) outst[i] = 1'b0;
      if (!core_req[i] && !outst[i] && next_op[i] < n_ops[i]) begin
        core_req[i]    = 1'b1;
        core_wrEn[i]   = ops[i][next_op[i]].wr;
        core_addr[i]   = ops[i][next_op[i]].addr;
        core_dataIn[i] = ops[i][next_op[i]].wr ? ops[i][next_op[i]].data : '0;
        req_cyc[i]     = cyc;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    monitor();
    drive();
  endtask

  function automatic bit all_done();
    bit d;
    d = (exp_q.size() == 0);
    for (int i = 0; i < CC; i++) if (outst[i] || next_op[i] < n_ops[i]) d = 1'b0;
    return d;
  endfunction

  task automatic run(input int budget);
    int k;
    k = 0;
    while (!all_done() && k < budget) begin
      step();
      k++;
    end
    if (!all_done()) begin
      check("timeout_pending", exp_q.size(), 0);
      flush();
    end
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    flush();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_gnt(input string tag);
    int base, k;
    base = gnt_cnt;
    k    = 0;
    while (gnt_cnt == base && k < 20) begin
      step();
      k++;
    end
    check(tag, gnt_cnt, base + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    core_req    = '0;
    core_wrEn   = '0;
    core_addr   = '0;
    core_dataIn = '0;
    cyc = 0; gnt_cyc = 0; gnt_cnt = 0; last_ack_cyc = 0;
    n_tests = 0; n_fail = 0;
    prev_busy = 1'b0; busy_at_ack = 1'b0; busy_before_ack = 1'b0;
    flush();
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset values
    check("rst_gnt",     32'(core_gnt), 0);
    check("rst_ack",     32'(core_ack), 0);
    check("rst_dout",    32'(core_dataOut), 0);
    check("rst_wren",    32'(ram_wrEn), 0);
    check("rst_addr",    32'(ram_addr), 0);
    check("rst_wdata",   32'(ram_dataIn), 0);
    check("rst_busy",    32'(busy), 0);

    // Single write, then read-back by another core
    add_op(1, 1'b1, 12'h010, 12'hABC);
    run(50);
    check("t1_gnt_latency", gnt_cyc_core[1] - req_cyc[1], 1);
    check("t1_ram_word", 32'(mem[12'h010]), 32'h0ABC);
    add_op(2, 1'b0, 12'h010, 12'hABC);
    run(50);

    // Address/data extremes
    add_op(0, 1'b1, 12'hFFF, 12'hFFF);
    run(50);
    add_op(1, 1'b1, 12'h000, 12'h000);
    run(50);
    add_op(0, 1'b0, 12'hFFF, 12'hFFF);
    run(50);
    add_op(1, 1'b0, 12'h000, 12'h000);
    run(50);

    // All four cores at once straight after reset: order 0,1,2,3 in 8 cycles
    do_reset();
    for (int i = 0; i < CC; i++) add_op(i, 1'b1, 12'(i), 12'(i + 1));
    run(50);
    check("t3_cycles", last_ack_cyc - req_cyc[0], 8);
    check("t3_busy_at_last_ack", 32'(busy_at_ack), 0);
    check("t3_busy_before_last_ack", 32'(busy_before_ack), 1);
    for (int i = 0; i < CC; i++) check("t3_ram_word", 32'(mem[i]), i + 1);

    // Two persistent requesters alternate; the others stay silent
    do_reset();
    for (int k = 0; k < 5; k++) begin
      add_op(0, 1'b1, 12'(12'h100 + k), 12'(12'h100 + k));
      add_op(3, 1'b1, 12'(12'h300 + k), 12'(12'h300 + k));
    end
    run(100);

    // Write aborted by reset at E1 leaves the RAM word untouched
    add_op(2, 1'b1, 12'h123, 12'h321);
    run(50);
    add_op(1, 1'b1, 12'h123, 12'h555);
    wait_gnt("t5_wr_gnt_seen");
    rst = 1'b1;
    flush();
    step();
    check("t5_wr_no_ack", 32'(core_ack), 0);
    check("t5_wr_busy", 32'(busy), 0);
    rst = 1'b0;
    step();
    check("t5_ram_unchanged", 32'(mem[12'h123]), 32'h0321);

    // Read aborted by reset in READ: no ack, back to IDLE, next core served
    add_op(0, 1'b0, 12'hFFF, 12'hFFF);
    wait_gnt("t5_rd_gnt_seen");
    step();
    rst = 1'b1;
    flush();
    step();
    check("t5_rd_no_ack", 32'(core_ack), 0);
    check("t5_rd_busy", 32'(busy), 0);
    check("t5_rd_wren", 32'(ram_wrEn), 0);
    check("t5_rd_dout", 32'(core_dataOut), 0);
    rst = 1'b0;
    step();
    add_op(3, 1'b0, 12'h123, 12'h321);
    run(50);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
